// File: rtl/kbd_pkg.sv
// kbd_pkg: prefix states, PS/2 set-2 scan codes and ASCII helpers
// shared by the keyboard event FIFO and its lookup table.
package kbd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } kbd_state_t;

  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CTRL     = 8'h14;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_PRTSC    = 8'h7C;
  localparam logic [7:0] SC_KP_ENTER = 8'h5A;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;

  localparam logic [7:0] ASC_NUL   = 8'h00;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_SLASH = 8'h2F;

  function automatic logic is_letter(
    input logic [7:0] c
  );
    return (c >= 8'h41 && c <= 8'h5A) ||
           (c >= 8'h61 && c <= 8'h7A);
  endfunction

  // key is {ext, code}; lut is the shifted lookup of code[6:0]
  function automatic logic [7:0] kbd_finish(
    input logic [8:0] key,
    input logic [7:0] lut,
    input logic       caps,
    input logic       ctrl
  );
    logic [7:0] c;
    c = ASC_NUL;
    if (key[8]) begin
      if (key[7:0] == SC_KP_ENTER)
        c = ASC_CR;
      else if (key[7:0] == SC_KP_SLASH)
        c = ASC_SLASH;
    end else if (!key[7]) begin
      c = lut;
      if (caps && is_letter(c))
        c = c ^ 8'h20;
      if (ctrl && (is_letter(c) ||
          (c >= 8'h5B && c <= 8'h5D)))
        c = c & 8'h1F;
    end
    return c;
  endfunction

endpackage

// File: rtl/kbd_ascii_lut.sv
// kbd_ascii_lut: registered set-2 scan code to ASCII lookup,
// one cycle of latency; unmapped codes give 00.
module kbd_ascii_lut (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift,
  input  logic [6:0] code,
  output logic [7:0] ascii
);

  logic [15:0] pair;

  always_comb begin
    pair = 16'h0000;
    case (code)
      7'h15: pair = 16'h7151;
      7'h1A: pair = 16'h7A5A;
      7'h1B: pair = 16'h7353;
      7'h1C: pair = 16'h6141;
      7'h1D: pair = 16'h7757;
      7'h21: pair = 16'h6343;
      7'h22: pair = 16'h7858;
      7'h23: pair = 16'h6444;
      7'h24: pair = 16'h6545;
      7'h2A: pair = 16'h7656;
      7'h2B: pair = 16'h6646;
      7'h2C: pair = 16'h7454;
      7'h2D: pair = 16'h7252;
      7'h31: pair = 16'h6E4E;
      7'h32: pair = 16'h6242;
      7'h33: pair = 16'h6848;
      7'h34: pair = 16'h6747;
      7'h35: pair = 16'h7959;
      7'h3A: pair = 16'h6D4D;
      7'h3B: pair = 16'h6A4A;
      7'h3C: pair = 16'h7555;
      7'h42: pair = 16'h6B4B;
      7'h43: pair = 16'h6949;
      7'h44: pair = 16'h6F4F;
      7'h4B: pair = 16'h6C4C;
      7'h4D: pair = 16'h7050;
      7'h16: pair = 16'h3121;
      7'h1E: pair = 16'h3240;
      7'h26: pair = 16'h3323;
      7'h25: pair = 16'h3424;
      7'h2E: pair = 16'h3525;
      7'h36: pair = 16'h365E;
      7'h3D: pair = 16'h3726;
      7'h3E: pair = 16'h382A;
      7'h46: pair = 16'h3928;
      7'h45: pair = 16'h3029;
      7'h0E: pair = 16'h607E;
      7'h4E: pair = 16'h2D5F;
      7'h55: pair = 16'h3D2B;
      7'h54: pair = 16'h5B7B;
      7'h5B: pair = 16'h5D7D;
      7'h5D: pair = 16'h5C7C;
      7'h4C: pair = 16'h3B3A;
      7'h52: pair = 16'h2722;
      7'h41: pair = 16'h2C3C;
      7'h49: pair = 16'h2E3E;
      7'h4A: pair = 16'h2F3F;
      7'h29: pair = 16'h2020;
      7'h5A: pair = 16'h0D0D;
      7'h66: pair = 16'h0808;
      7'h0D: pair = 16'h0909;
      7'h76: pair = 16'h1B1B;
      default: pair = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ascii <= 8'h00;
    else
      ascii <= shift ? pair[7:0] : pair[15:8];
  end

endmodule

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: PS/2 decode, modifiers, typematic repeat, char FIFO.
// Define KBD_CTRL_CODES_EN to map ctrl+letter/[\] to control codes.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMER_W = 25,
  parameter logic [TIMER_W-1:0] DELAY_FIRST = 25'd25_000_000,
  parameter logic [TIMER_W-1:0] DELAY_REPEAT = 25'd1_666_667
) (
  input  logic       clk_50,
  input  logic       clrn,
  input  logic       sc_valid,
  input  logic [7:0] sc_data,
  output logic       sc_ready,
  input  logic       kbd_en,
  input  logic       kbd_pop,
  output logic       kbd_valid,
  output logic [7:0] kbd_char,
  output logic [7:0] kbd_count,
  output logic       kbd_overflow,
  output logic [2:0] mods
);

  localparam int AW = $clog2(FIFO_DEPTH);

  kbd_state_t state, state_n;
  logic accept, fake;
  logic ev_make, ev_brk, ev_ext;
  logic [8:0] ev_key;
  logic lshift, rshift, lctrl, rctrl;
  logic caps_held, caps_lock;
  logic shift, ctrl, ctrl_codes;
  logic s1, s2;
  logic [8:0] pend;
  logic [7:0] lut_q;
  logic rep_active;
  logic [8:0] rep_key;
  logic [TIMER_W-1:0] timer;
  logic [7:0] mk_char, rep_char, push_char;
  logic mk_push, rep_fire, rep_kill;
  logic push_req, can_push, do_push, do_pop;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [8:0] count, count_n;
  logic [7:0] head_n;

  assign sc_ready = !(s1 || s2);
  assign accept = sc_valid && sc_ready;
  assign fake = (sc_data == SC_LSHIFT) ||
                (sc_data == SC_PRTSC);
  assign shift = lshift || rshift;
  assign ctrl = lctrl || rctrl;
  assign mods = {caps_lock, ctrl, shift};

`ifdef KBD_CTRL_CODES_EN
  assign ctrl_codes = ctrl;
`else
  assign ctrl_codes = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ev_make = 1'b0;
    ev_brk = 1'b0;
    ev_ext = 1'b0;
    if (accept) begin
      state_n = S_IDLE;
      if (sc_data != SC_PAUSE) begin
        unique case (state)
          S_IDLE: begin
            if (sc_data == SC_BREAK)
              state_n = S_BRK;
            else if (sc_data == SC_EXT)
              state_n = S_EXT;
            else
              ev_make = 1'b1;
          end
          S_EXT: begin
            ev_ext = 1'b1;
            if (sc_data == SC_BREAK)
              state_n = S_EXT_BRK;
            else
              ev_make = !fake;
          end
          S_BRK: ev_brk = 1'b1;
          S_EXT_BRK: begin
            ev_ext = 1'b1;
            ev_brk = !fake;
          end
        endcase
      end
    end
  end

  assign ev_key = {ev_ext, sc_data};

  always_ff @(posedge clk_50 or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
      s1 <= 1'b0;
      s2 <= 1'b0;
      pend <= '0;
      lshift <= 1'b0;
      rshift <= 1'b0;
      lctrl <= 1'b0;
      rctrl <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else begin
      state <= state_n;
      s1 <= ev_make;
      s2 <= s1;
      if (ev_make)
        pend <= ev_key;
      if (ev_make || ev_brk) begin
        case (ev_key)
          {1'b0, SC_LSHIFT}: lshift <= ev_make;
          {1'b0, SC_RSHIFT}: rshift <= ev_make;
          {1'b0, SC_CTRL}:   lctrl <= ev_make;
          {1'b1, SC_CTRL}:   rctrl <= ev_make;
          {1'b0, SC_CAPS}: begin
            caps_held <= ev_make;
            if (ev_make && !caps_held)
              caps_lock <= !caps_lock;
          end
          default: ;
        endcase
      end
    end
  end

  // LUT follows rep_key whenever no make is being looked up
  kbd_ascii_lut u_lut (
    .clk   (clk_50),
    .rst_n (clrn),
    .shift (shift),
    .code  (s1 ? pend[6:0] : rep_key[6:0]),
    .ascii (lut_q)
  );

  assign mk_char = kbd_finish(pend, lut_q,
                              caps_lock, ctrl_codes);
  assign rep_char = kbd_finish(rep_key, lut_q,
                               caps_lock, ctrl_codes);
  assign mk_push = s2 && (mk_char != ASC_NUL) &&
                   !(rep_active && pend == rep_key);
  assign rep_kill = ev_brk && (ev_key == rep_key);
  assign rep_fire = rep_active && !s2 && !rep_kill &&
                    (timer == TIMER_W'(1));

  // a fire landing on a make's push cycle waits one cycle at 1
  always_ff @(posedge clk_50 or negedge clrn) begin
    if (!clrn) begin
      rep_active <= 1'b0;
      rep_key <= '0;
      timer <= '0;
    end else if (mk_push) begin
      rep_active <= 1'b1;
      rep_key <= pend;
      timer <= DELAY_FIRST;
    end else if (rep_active) begin
      if (timer != TIMER_W'(1))
        timer <= timer - TIMER_W'(1);
      else if (rep_fire)
        timer <= DELAY_REPEAT;
      if (rep_kill)
        rep_active <= 1'b0;
    end
  end

  assign push_req = mk_push || rep_fire;
  assign push_char = mk_push ? mk_char : rep_char;
  assign kbd_valid = (count != 9'd0);
  assign kbd_count = (count > 9'd255) ? 8'hFF : count[7:0];
  assign do_pop = kbd_en && kbd_pop && kbd_valid;
  assign can_push = kbd_en &&
                    (count != 9'(FIFO_DEPTH) || do_pop);
  assign do_push = push_req && can_push;
  assign rd_n = rd_ptr + AW'(do_pop);
  assign count_n = count + 9'(do_push) - 9'(do_pop);
  assign head_n = (do_push && wr_ptr == rd_n) ?
                  push_char : mem[rd_n];

  always_ff @(posedge clk_50) begin
    if (do_push)
      mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk_50 or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      kbd_overflow <= 1'b0;
      kbd_char <= 8'h00;
    end else if (!kbd_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      kbd_overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_n;
      count <= count_n;
      if (push_req && !can_push)
        kbd_overflow <= 1'b1;
      if (count_n != 9'd0)
        kbd_char <= head_n;
    end
  end

endmodule
